qtable_nexthop_reader: RTL and testbench
========================================

# qtable_nexthop_reader

Read-side counterpart of the Q-table update logic: on a start pulse it scans the neighbor table (written by the Q-table update block) through a synchronous-read port and selects the neighbor with the highest Q-value. It then presents the fields of an outgoing data packet addressed to that neighbor. It sits between the neighbor/Q-value memory banks and the packet transmitter.

## Interface
- WORD_WIDTH, 16, width of every table/packet field
- MAX_NEIGHBORS, 32, table depth; index width = clog2(MAX_NEIGHBORS)
- DATA_PKT, 3'b101, packet type emitted on pPacketType
- clk  input  1  single clock, rising edge
- nrst  input  1  reset; asynchronous, active-low
- en  input  1  start pulse; sampled only in IDLE
- myNodeID, myHops, myEnergy  input  WORD_WIDTH each  own node fields
- minEnergy  input  WORD_WIDTH  eligibility threshold (Q2.14 unsigned)
- neighborCount  input  WORD_WIDTH  number of valid table entries
- rd_en  output  1  memory read strobe
- rd_addr  output  clog2(MAX_NEIGHBORS)  table index
- mNeighborID, mHops, mEnergyLeft, mQValue  input  WORD_WIDTH each  table read data, valid one cycle after rd_en/rd_addr are sampled
- pSourceID, pDestID, pHops, pEnergyLeft, pQValue  output  WORD_WIDTH each  outgoing packet fields
- pPacketType  output  3  packet type
- noRoute  output  1  no eligible neighbor found
- busy  output  1  scan in progress
- done  output  1  one-cycle completion pulse

## Operation
- Energy and Q-values are unsigned Q2.14: 16'h4000 = 1.0, 16'h3000 = 0.75, 16'h8000 = 2.0.
- States: IDLE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE, en=1:
  - Latch N = min(neighborCount, MAX_NEIGHBORS).
  - Clear the found flag.
  - If N=0, go to DRAIN with no reads; otherwise go to READ with rd_addr=0 and rd_en=1.
- READ:
  - Present addresses 0..N-1 on consecutive cycles with rd_en=1.
  - After address N-1, go to DRAIN with rd_en=0.
- Compare stage: each returned entry is evaluated one cycle after its address.
  - An entry is eligible iff mEnergyLeft >= minEnergy.
  - An eligible entry replaces the current best if no best exists yet, if mQValue > bestQ, or if mQValue == bestQ and mHops < bestHops.
  - On a full tie the lower index wins.
  - A Q-value of 0 is a valid candidate; the found flag, not bestQ=0, marks "none".
- DRAIN: absorb the final read-data cycle, then go to DONE.
- DONE: register the packet fields, pulse done for one cycle, return to IDLE.
  - pSourceID = myNodeID.
  - pDestID = bestID.
  - pHops = myHops + 1, saturating at 16'hFFFF.
  - pEnergyLeft = myEnergy.
  - pQValue = bestQ.
  - pPacketType = DATA_PKT.
- No eligible entry: noRoute=1, pDestID=16'hFFFF, pQValue=0; the remaining fields are as above.
- Packet outputs and noRoute hold their values until the next done pulse.
- en outside IDLE is ignored. neighborCount, minEnergy and the my* inputs are sampled at the start edge only.

## Timing
- Reset (async, nrst=0):
  - State = IDLE.
  - rd_en=0, rd_addr=0, busy=0, done=0, noRoute=0.
  - All p* outputs = 0.
  - Internal best registers cleared.
  - Reset mid-scan aborts the scan with no done pulse.
- Let E0 be the edge at which en=1 is sampled in IDLE.
  - rd_addr=k and rd_en=1 after edge Ek, for k = 0..N-1.
  - Entry k is compared at edge E(k+2).
  - done=1 from edge E(N+2) for exactly one cycle, with outputs valid at the same edge.
  - Total latency is N+2 cycles; for N=0, done rises at E2.
- busy=1 from E0 until the edge at which done rises; busy and done never overlap.
- en=1 in the same cycle as done (state DONE) is ignored. A new scan can be accepted the cycle after done.

## Test plan
- Reset and basic scan:
  - Stimulus: reset, then N=3, entries {ID 5, Q 16'h3000, hops 2}, {ID 7, Q 16'h4000, hops 4}, {ID 9, Q 16'h2000, hops 1}, all energy 16'h8000, minEnergy 16'h1000, myHops 2.
  - Response: pDestID=7, pQValue=16'h4000, pHops=3, noRoute=0, done at E5.
- Tie-break:
  - Stimulus: two entries with Q 16'h3000, hops 3 (ID 4) and hops 1 (ID 6), followed by a third entry with Q 16'h3000, hops 1 (ID 8).
  - Response: pDestID=6.
- Energy filter:
  - Stimulus: highest-Q entry has energy 16'h0800 and minEnergy=16'h1000.
  - Response: that entry is skipped and the next-best entry is chosen. With all entries below threshold: noRoute=1, pDestID=16'hFFFF.
- Boundaries:
  - N=0: done at E2 with noRoute=1 and no rd_en pulse.
  - neighborCount=40 with MAX_NEIGHBORS=32: exactly 32 reads, done at E34.
  - myHops=16'hFFFF: pHops=16'hFFFF.
- Control robustness:
  - en held high throughout a scan: single scan, single done pulse.
  - nrst low at E2 of an N=5 scan: all outputs return to 0 and no done pulse.
  - A later scan after reset completes normally.

Source files
------------

// File: rtl/qtable_nexthop_reader.sv
// qtable_nexthop_reader
//
// Scans the neighbor table through a synchronous-read port after a start
// pulse and selects the eligible neighbor with the highest Q-value. The
// selection is turned into the fields of an outgoing data packet for the
// transmitter.
//
// Ports:
//   clk, nrst            clock (rising edge), asynchronous active-low reset
//   en                   start pulse, honoured only while idle
//   myNodeID/myHops/myEnergy  own node fields, captured at the start edge
//   minEnergy            eligibility threshold (Q2.14), captured at start
//   neighborCount        number of valid entries, clamped to MAX_NEIGHBORS
//   rd_en, rd_addr       table read strobe and index
//   mNeighborID, mHops, mEnergyLeft, mQValue
//                        table read data, valid one cycle after the read
//   pSourceID, pDestID, pHops, pEnergyLeft, pQValue, pPacketType
//                        packet fields, held until the next done pulse
//   noRoute              no eligible neighbor was found in the last scan
//   busy                 scan in progress
//   done                 one-cycle completion pulse
module qtable_nexthop_reader #(
    parameter int          WORD_WIDTH    = 16,
    parameter int          MAX_NEIGHBORS = 32,
    parameter logic [2:0]  DATA_PKT      = 3'b101
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              en,
    input  logic [WORD_WIDTH-1:0]             myNodeID,
    input  logic [WORD_WIDTH-1:0]             myHops,
    input  logic [WORD_WIDTH-1:0]             myEnergy,
    input  logic [WORD_WIDTH-1:0]             minEnergy,
    input  logic [WORD_WIDTH-1:0]             neighborCount,
    output logic                              rd_en,
    output logic [$clog2(MAX_NEIGHBORS)-1:0]  rd_addr,
    input  logic [WORD_WIDTH-1:0]             mNeighborID,
    input  logic [WORD_WIDTH-1:0]             mHops,
    input  logic [WORD_WIDTH-1:0]             mEnergyLeft,
    input  logic [WORD_WIDTH-1:0]             mQValue,
    output logic [WORD_WIDTH-1:0]             pSourceID,
    output logic [WORD_WIDTH-1:0]             pDestID,
    output logic [WORD_WIDTH-1:0]             pHops,
    output logic [WORD_WIDTH-1:0]             pEnergyLeft,
    output logic [WORD_WIDTH-1:0]             pQValue,
    output logic [2:0]                        pPacketType,
    output logic                              noRoute,
    output logic                              busy,
    output logic                              done
);

    localparam int IDX_W = $clog2(MAX_NEIGHBORS);
    localparam logic [WORD_WIDTH-1:0] MAX_N = WORD_WIDTH'(MAX_NEIGHBORS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_NEIGHBORS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, stateNext;

    logic                  rdEnNext;
    logic [IDX_W-1:0]      rdAddrNext;
    logic                  startScan;
    logic                  finishScan;

    logic [IDX_W-1:0]      lastAddr;
    logic [WORD_WIDTH-1:0] countMinusOne;
    logic [IDX_W-1:0]      lastAddrStart;

    logic                  cmpValid;
    logic                  found;
    logic [WORD_WIDTH-1:0] bestId;
    logic [WORD_WIDTH-1:0] bestQ;
    logic [WORD_WIDTH-1:0] bestHops;

    logic [WORD_WIDTH-1:0] minEnergyQ;
    logic [WORD_WIDTH-1:0] myNodeIdQ;
    logic [WORD_WIDTH-1:0] myHopsQ;
    logic [WORD_WIDTH-1:0] myEnergyQ;

    logic                  eligible;
    logic                  better;

    // Index of the last entry to read; counts above the table depth are
    // clamped so the scan never runs past the end of the memory.
    assign countMinusOne = neighborCount - 1'b1;
    assign lastAddrStart = (neighborCount >= MAX_N) ? LAST_IDX
                                                    : countMinusOne[IDX_W-1:0];

    // Strict comparisons mean an equal entry seen later never displaces the
    // earlier one, which gives the lower index the win on a full tie.
    assign eligible = (mEnergyLeft >= minEnergy_sel());
    assign better   = !found || (mQValue > bestQ) ||
                      ((mQValue == bestQ) && (mHops < bestHops));

    function automatic logic [WORD_WIDTH-1:0] minEnergy_sel();
        return minEnergyQ;
    endfunction

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and read-port sequencing. A start request is refused in the
    // cycle done is high so a held en cannot chain straight into a new scan.
    always_comb begin
        stateNext  = state;
        rdEnNext   = 1'b0;
        rdAddrNext = rd_addr;
        startScan  = 1'b0;
        finishScan = 1'b0;
        case (state)
            IDLE: begin
                if (en && !done) begin
                    startScan  = 1'b1;
                    rdAddrNext = '0;
                    if (neighborCount == '0) begin
                        stateNext = DRAIN;
                    end else begin
                        stateNext = READ;
                        rdEnNext  = 1'b1;
                    end
                end
            end
            READ: begin
                if (rd_addr == lastAddr) begin
                    stateNext = DRAIN;
                end else begin
                    rdEnNext   = 1'b1;
                    rdAddrNext = rd_addr + 1'b1;
                end
            end
            DRAIN: begin
                stateNext = DONE;
            end
            DONE: begin
                stateNext  = IDLE;
                finishScan = 1'b1;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Read port registers; cmpValid marks the cycle in which the returned
    // data belongs to a read issued by this scan.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            cmpValid <= 1'b0;
        end else begin
            rd_en    <= rdEnNext;
            rd_addr  <= rdAddrNext;
            cmpValid <= rd_en;
        end
    end

    // Input capture at the start edge and best-candidate tracking. The found
    // flag, not a zero Q-value, distinguishes "no candidate yet".
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lastAddr   <= '0;
            minEnergyQ <= '0;
            myNodeIdQ  <= '0;
            myHopsQ    <= '0;
            myEnergyQ  <= '0;
            found      <= 1'b0;
            bestId     <= '0;
            bestQ      <= '0;
            bestHops   <= '0;
        end else if (startScan) begin
            lastAddr   <= lastAddrStart;
            minEnergyQ <= minEnergy;
            myNodeIdQ  <= myNodeID;
            myHopsQ    <= myHops;
            myEnergyQ  <= myEnergy;
            found      <= 1'b0;
            bestId     <= '0;
            bestQ      <= '0;
            bestHops   <= '0;
        end else if (cmpValid && eligible && better) begin
            found      <= 1'b1;
            bestId     <= mNeighborID;
            bestQ      <= mQValue;
            bestHops   <= mHops;
        end
    end

    // Packet registers load once per scan and hold until the next done.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            done        <= 1'b0;
            noRoute     <= 1'b0;
            pSourceID   <= '0;
            pDestID     <= '0;
            pHops       <= '0;
            pEnergyLeft <= '0;
            pQValue     <= '0;
            pPacketType <= '0;
        end else begin
            done <= finishScan;
            if (finishScan) begin
                pSourceID   <= myNodeIdQ;
                pHops       <= (myHopsQ == '1) ? '1 : myHopsQ + 1'b1;
                pEnergyLeft <= myEnergyQ;
                pPacketType <= DATA_PKT;
                noRoute     <= !found;
                pDestID     <= found ? bestId : '1;
                pQValue     <= found ? bestQ : '0;
            end
        end
    end

endmodule

// File: tb/tb_qtable_nexthop_reader.sv
module tb_qtable_nexthop_reader;

    logic        clk;
    logic        nrst;
    logic        en;
    logic [15:0] myNodeID, myHops, myEnergy, minEnergy, neighborCount;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [15:0] mNeighborID, mHops, mEnergyLeft, mQValue;
    logic [15:0] pSourceID, pDestID, pHops, pEnergyLeft, pQValue;
    logic [2:0]  pPacketType;
    logic        noRoute, busy, done;

    int errors = 0;
    int checks = 0;

    // Neighbor table contents served to the DUT.
    logic [15:0] memId[32];
    logic [15:0] memHops[32];
    logic [15:0] memEnergy[32];
    logic [15:0] memQ[32];

    typedef struct {
        string       name;
        int          cnt;
        logic [15:0] minE;
        logic [15:0] myH;
        logic [2:0][15:0] ids;
        logic [2:0][15:0] qs;
        logic [2:0][15:0] hops;
        logic [2:0][15:0] energies;
        logic [15:0] expDest;
        logic [15:0] expQ;
        logic [15:0] expHops;
        logic        expNoRoute;
    } vector_t;

    vector_t vecs[7];

    qtable_nexthop_reader dut (
        .clk(clk), .nrst(nrst), .en(en),
        .myNodeID(myNodeID), .myHops(myHops), .myEnergy(myEnergy),
        .minEnergy(minEnergy), .neighborCount(neighborCount),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .mNeighborID(mNeighborID), .mHops(mHops),
        .mEnergyLeft(mEnergyLeft), .mQValue(mQValue),
        .pSourceID(pSourceID), .pDestID(pDestID), .pHops(pHops),
        .pEnergyLeft(pEnergyLeft), .pQValue(pQValue),
        .pPacketType(pPacketType), .noRoute(noRoute),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en) begin
            mNeighborID <= memId[rd_addr];
            mHops       <= memHops[rd_addr];
            mEnergyLeft <= memEnergy[rd_addr];
            mQValue     <= memQ[rd_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference selection: find the best Q among eligible entries, then the
    // fewest hops among those, then the first index holding both.
    function automatic void referenceModel(input int cnt, input logic [15:0] minE,
                                           input logic [15:0] myH,
                                           output logic [15:0] dest,
                                           output logic [15:0] q,
                                           output logic [15:0] hopsOut,
                                           output logic nr);
        int n;
        int maxQ;
        int minH;
        bit any;
        n = (cnt > 32) ? 32 : cnt;
        any = 0;
        maxQ = -1;
        for (int i = 0; i < n; i++)
            if (memEnergy[i] >= minE) begin
                any = 1;
                if (int'(memQ[i]) > maxQ) maxQ = int'(memQ[i]);
            end
        minH = 65536;
        for (int i = 0; i < n; i++)
            if (memEnergy[i] >= minE && int'(memQ[i]) == maxQ && int'(memHops[i]) < minH)
                minH = int'(memHops[i]);
        dest = 16'hFFFF;
        q = 16'h0000;
        nr = !any;
        if (any) begin
            q = 16'(maxQ);
            for (int i = n - 1; i >= 0; i--)
                if (memEnergy[i] >= minE && int'(memQ[i]) == maxQ && int'(memHops[i]) == minH)
                    dest = memId[i];
        end
        hopsOut = (int'(myH) + 1 > 65535) ? 16'hFFFF : 16'(int'(myH) + 1);
    endfunction

    // Starts one scan and follows it to the done pulse, recording latency in
    // cycles after the start edge, number of reads, address ordering and
    // busy/done overlap.
    task automatic applyStimulus(input int cnt, input logic [15:0] minE,
                                 input logic [15:0] myId, input logic [15:0] myH,
                                 input logic [15:0] myE, input bit holdEn,
                                 output int latency, output int reads,
                                 output bit addrOk, output bit overlapOk);
        int c;
        @(negedge clk);
        neighborCount = 16'(cnt);
        minEnergy = minE;
        myNodeID = myId;
        myHops = myH;
        myEnergy = myE;
        en = 1'b1;
        @(posedge clk);
        #1;
        if (!holdEn) en = 1'b0;
        // Scramble captured inputs to show they are sampled only at start.
        neighborCount = 16'h0003;
        minEnergy = 16'($urandom);
        myNodeID = 16'($urandom);
        myHops = 16'($urandom);
        myEnergy = 16'($urandom);
        latency = -1;
        reads = 0;
        addrOk = 1;
        overlapOk = 1;
        c = 0;
        while (c < 100) begin
            if (busy && done) overlapOk = 0;
            if (rd_en) begin
                if (int'(rd_addr) != reads) addrOk = 0;
                reads++;
            end
            if (done) begin
                latency = c;
                break;
            end
            @(posedge clk);
            #1;
            c++;
        end
        en = 1'b0;
    endtask

    task automatic checkScan(input string name, input int cnt,
                             input logic [15:0] myId, input logic [15:0] myE,
                             input logic [15:0] expDest, input logic [15:0] expQ,
                             input logic [15:0] expHops, input logic expNr,
                             input int latency, input int reads,
                             input bit addrOk, input bit overlapOk);
        int n;
        n = (cnt > 32) ? 32 : cnt;
        checkOutput({name, ".latency"}, 32'(latency), 32'(n + 2));
        checkOutput({name, ".reads"}, 32'(reads), 32'(n));
        checkOutput({name, ".addrOrder"}, 32'(addrOk), 32'd1);
        checkOutput({name, ".busyDone"}, 32'(overlapOk), 32'd1);
        checkOutput({name, ".pDestID"}, 32'(pDestID), 32'(expDest));
        checkOutput({name, ".pQValue"}, 32'(pQValue), 32'(expQ));
        checkOutput({name, ".pHops"}, 32'(pHops), 32'(expHops));
        checkOutput({name, ".noRoute"}, 32'(noRoute), 32'(expNr));
        checkOutput({name, ".pSourceID"}, 32'(pSourceID), 32'(myId));
        checkOutput({name, ".pEnergyLeft"}, 32'(pEnergyLeft), 32'(myE));
        checkOutput({name, ".pPacketType"}, 32'(pPacketType), 32'h5);
        @(posedge clk);
        #1;
        checkOutput({name, ".donePulse"}, 32'(done), 32'd0);
        checkOutput({name, ".holdDest"}, 32'(pDestID), 32'(expDest));
    endtask

    task automatic loadVector(input vector_t v);
        for (int i = 0; i < 3; i++) begin
            memId[i] = v.ids[i];
            memQ[i] = v.qs[i];
            memHops[i] = v.hops[i];
            memEnergy[i] = v.energies[i];
        end
    endtask

    initial begin
        int lat, rd;
        bit aOk, oOk;
        logic [15:0] eDest, eQ, eHops, myId, myE;
        logic eNr;
        int cnt, doneSeen;
        logic [15:0] minE, myH;

        en = 0;
        nrst = 0;
        myNodeID = 0; myHops = 0; myEnergy = 0; minEnergy = 0; neighborCount = 0;
        mNeighborID = 0; mHops = 0; mEnergyLeft = 0; mQValue = 0;
        for (int i = 0; i < 32; i++) begin
            memId[i] = 16'(100 + i);
            memHops[i] = 0;
            memEnergy[i] = 0;
            memQ[i] = 0;
        end

        vecs[0] = '{"basic", 3, 16'h1000, 16'd2,
                    {16'd9, 16'd7, 16'd5}, {16'h2000, 16'h4000, 16'h3000},
                    {16'd1, 16'd4, 16'd2}, {16'h8000, 16'h8000, 16'h8000},
                    16'd7, 16'h4000, 16'd3, 1'b0};
        vecs[1] = '{"tie", 3, 16'h1000, 16'd5,
                    {16'd8, 16'd6, 16'd4}, {16'h3000, 16'h3000, 16'h3000},
                    {16'd1, 16'd1, 16'd3}, {16'h8000, 16'h8000, 16'h8000},
                    16'd6, 16'h3000, 16'd6, 1'b0};
        vecs[2] = '{"energyFilter", 3, 16'h1000, 16'd2,
                    {16'd9, 16'd7, 16'd5}, {16'h2000, 16'h4000, 16'h3000},
                    {16'd1, 16'd4, 16'd2}, {16'h8000, 16'h0800, 16'h8000},
                    16'd5, 16'h3000, 16'd3, 1'b0};
        vecs[3] = '{"allBelow", 3, 16'h1000, 16'd2,
                    {16'd9, 16'd7, 16'd5}, {16'h2000, 16'h4000, 16'h3000},
                    {16'd1, 16'd4, 16'd2}, {16'h0000, 16'h0FFF, 16'h0800},
                    16'hFFFF, 16'h0000, 16'd3, 1'b1};
        vecs[4] = '{"emptyTable", 0, 16'h1000, 16'd2,
                    {16'd9, 16'd7, 16'd5}, {16'h2000, 16'h4000, 16'h3000},
                    {16'd1, 16'd4, 16'd2}, {16'h8000, 16'h8000, 16'h8000},
                    16'hFFFF, 16'h0000, 16'd3, 1'b1};
        vecs[5] = '{"hopsSaturate", 3, 16'h1000, 16'hFFFF,
                    {16'd9, 16'd7, 16'd5}, {16'h2000, 16'h4000, 16'h3000},
                    {16'd1, 16'd4, 16'd2}, {16'h8000, 16'h8000, 16'h8000},
                    16'd7, 16'h4000, 16'hFFFF, 1'b0};
        vecs[6] = '{"zeroQ", 3, 16'h1000, 16'd0,
                    {16'd13, 16'd12, 16'd11}, {16'h0000, 16'h0000, 16'h0000},
                    {16'd2, 16'd2, 16'd5}, {16'h1000, 16'h1000, 16'h1000},
                    16'd12, 16'h0000, 16'd1, 1'b0};

        // Reset state.
        #12;
        checkOutput("reset.rd_en", 32'(rd_en), 0);
        checkOutput("reset.busy", 32'(busy), 0);
        checkOutput("reset.done", 32'(done), 0);
        checkOutput("reset.noRoute", 32'(noRoute), 0);
        checkOutput("reset.pDestID", 32'(pDestID), 0);
        checkOutput("reset.pPacketType", 32'(pPacketType), 0);
        @(negedge clk);
        nrst = 1;

        // Directed table.
        for (int v = 0; v < 7; v++) begin
            loadVector(vecs[v]);
            myId = 16'h00A0 + 16'(v);
            myE = 16'h3000 + 16'(v);
            applyStimulus(vecs[v].cnt, vecs[v].minE, myId, vecs[v].myH, myE, 0,
                          lat, rd, aOk, oOk);
            checkScan(vecs[v].name, vecs[v].cnt, myId, myE, vecs[v].expDest,
                      vecs[v].expQ, vecs[v].expHops, vecs[v].expNoRoute,
                      lat, rd, aOk, oOk);
        end

        // Randomized scans against the reference model.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 32; i++) begin
                memId[i] = 16'($urandom);
                memQ[i] = 16'($urandom_range(0, 3) * 16'h1000);
                memHops[i] = 16'($urandom_range(0, 3));
                memEnergy[i] = 16'($urandom);
            end
            cnt = $urandom_range(0, 35);
            minE = 16'($urandom);
            myH = (t == 3) ? 16'hFFFF : 16'($urandom);
            myId = 16'($urandom);
            myE = 16'($urandom);
            referenceModel(cnt, minE, myH, eDest, eQ, eHops, eNr);
            applyStimulus(cnt, minE, myId, myH, myE, 0, lat, rd, aOk, oOk);
            checkScan("random", cnt, myId, myE, eDest, eQ, eHops, eNr,
                      lat, rd, aOk, oOk);
        end

        // Oversized neighborCount is clamped to the table depth.
        for (int i = 0; i < 32; i++) begin
            memId[i] = 16'(200 + i);
            memQ[i] = 16'(i * 16'h0100);
            memHops[i] = 16'd1;
            memEnergy[i] = 16'h8000;
        end
        referenceModel(40, 16'h1000, 16'd4, eDest, eQ, eHops, eNr);
        applyStimulus(40, 16'h1000, 16'h0011, 16'd4, 16'h2222, 0, lat, rd, aOk, oOk);
        checkScan("clamp40", 40, 16'h0011, 16'h2222, eDest, eQ, eHops, eNr,
                  lat, rd, aOk, oOk);

        // en held high for the whole scan: only one scan may run.
        loadVector(vecs[0]);
        applyStimulus(3, 16'h1000, 16'h0022, 16'd2, 16'h3333, 1, lat, rd, aOk, oOk);
        checkScan("holdEn", 3, 16'h0022, 16'h3333, 16'd7, 16'h4000, 16'd3, 1'b0,
                  lat, rd, aOk, oOk);
        checkOutput("holdEn.idleAfter", 32'(busy), 0);

        // Reset asserted at E2 of an N=5 scan aborts it.
        for (int i = 0; i < 5; i++) begin
            memId[i] = 16'(50 + i);
            memQ[i] = 16'h1000;
            memHops[i] = 16'd1;
            memEnergy[i] = 16'h8000;
        end
        @(negedge clk);
        neighborCount = 16'd5;
        minEnergy = 16'h0100;
        myNodeID = 16'h0033;
        myHops = 16'd1;
        myEnergy = 16'h4444;
        en = 1;
        @(posedge clk);
        #1;
        en = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        nrst = 0;
        #1;
        checkOutput("midReset.rd_en", 32'(rd_en), 0);
        checkOutput("midReset.rd_addr", 32'(rd_addr), 0);
        checkOutput("midReset.busy", 32'(busy), 0);
        checkOutput("midReset.pDestID", 32'(pDestID), 0);
        checkOutput("midReset.pHops", 32'(pHops), 0);
        checkOutput("midReset.pSourceID", 32'(pSourceID), 0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1;
        doneSeen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (done) doneSeen++;
        end
        checkOutput("midReset.noDone", 32'(doneSeen), 0);

        // A scan after the reset completes normally.
        referenceModel(5, 16'h0100, 16'd1, eDest, eQ, eHops, eNr);
        applyStimulus(5, 16'h0100, 16'h0044, 16'd1, 16'h5555, 0, lat, rd, aOk, oOk);
        checkScan("afterReset", 5, 16'h0044, 16'h5555, eDest, eQ, eHops, eNr,
                  lat, rd, aOk, oOk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
